// File: rtl/led_pattern_engine.sv
// LED pattern engine: key-driven mode/speed/pause control over four pattern generators.
// Optional macro LED_PWM_EN adds a 2-bit brightness register and 16-step PWM dimming of the LEDs.
module led_pattern_engine #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_status,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [2:0]  KEY_SHORT  = 3'd1;
  localparam logic [2:0]  KEY_LONG   = 3'd2;
  localparam logic [2:0]  KEY_DOUBLE = 3'd3;

  logic [2:0]        r_prev_key;
  logic [TICK_W-1:0] r_tick;
  logic [1:0]        r_step;
  logic [1:0]        r_speed;
  logic [1:0]        r_mode;
  logic              r_paused;
  logic [3:0]        r_pattern;
  logic [3:0]        r_led;

  logic              w_accept;
  logic              w_tick;
  logic              w_step_fire;
  logic [1:0]        w_period_m1;
  logic [3:0]        w_led_mask;
  logic [TICK_W-1:0] w_tick_nx;
  logic [1:0]        w_step_nx;
  logic [1:0]        w_speed_nx;
  logic [1:0]        w_mode_nx;
  logic              w_paused_nx;
  logic [3:0]        w_pattern_nx;

  function automatic logic [3:0] init_pattern(input logic [1:0] m);
    case (m)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] step_pattern(input logic [1:0] m, input logic [3:0] p);
    case (m)
      2'd1:    return {p[2:0], p[3]};
      2'd2:    return ~p;
      2'd3:    return p + 4'd1;
      default: return p;
    endcase
  endfunction

  // Only a rising edge out of idle counts as a key event.
  assign w_accept    = (key_status != 3'd0) && (r_prev_key == 3'd0);
  assign w_tick      = !r_paused && (r_tick == TICK_W'(TICK_DIV - 1));
  assign w_period_m1 = (r_speed == 2'd0) ? 2'd3 : ((r_speed == 2'd1) ? 2'd1 : 2'd0);
  assign w_step_fire = w_tick && (r_step == w_period_m1);

  // Step first, then let the event override; a mode change reload wins over the step.
  always_comb begin
    w_tick_nx    = r_tick;
    w_step_nx    = r_step;
    w_speed_nx   = r_speed;
    w_mode_nx    = r_mode;
    w_paused_nx  = r_paused;
    w_pattern_nx = r_pattern;
    if (!r_paused) begin
      if (w_tick) begin
        w_tick_nx = '0;
        if (w_step_fire) begin
          w_step_nx    = 2'd0;
          w_pattern_nx = step_pattern(r_mode, r_pattern);
        end else begin
          w_step_nx = r_step + 2'd1;
        end
      end else begin
        w_tick_nx = r_tick + TICK_W'(1);
      end
    end
    if (w_accept) begin
      case (key_status)
        KEY_SHORT: begin
          w_mode_nx    = r_mode + 2'd1;
          w_pattern_nx = init_pattern(w_mode_nx);
          w_tick_nx    = '0;
          w_step_nx    = 2'd0;
        end
        KEY_LONG: begin
          w_speed_nx = (r_speed == 2'd2) ? 2'd0 : r_speed + 2'd1;
          w_tick_nx  = '0;
          w_step_nx  = 2'd0;
        end
        KEY_DOUBLE: w_paused_nx = !r_paused;
        default: ;
      endcase
    end
  end

`ifdef LED_PWM_EN
  localparam logic [2:0] KEY_BRIGHT = 3'd4;
  logic [1:0] r_bright;
  logic [3:0] r_pwm;

  // Duty of 4*(brightness+1) out of 16 PWM slots.
  assign w_led_mask = ({1'b0, r_pwm} < ({1'b0, r_bright, 2'b00} + 5'd4)) ? 4'hF : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bright <= 2'd3;
      r_pwm    <= 4'd0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (w_accept && (key_status == KEY_BRIGHT)) r_bright <= r_bright - 2'd1;
    end
  end
`else
  assign w_led_mask = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_key <= 3'd0;
      r_tick     <= '0;
      r_step     <= 2'd0;
      r_speed    <= 2'd0;
      r_mode     <= 2'd0;
      r_paused   <= 1'b0;
      r_pattern  <= 4'd0;
      r_led      <= 4'd0;
    end else begin
      r_prev_key <= key_status;
      r_tick     <= w_tick_nx;
      r_step     <= w_step_nx;
      r_speed    <= w_speed_nx;
      r_mode     <= w_mode_nx;
      r_paused   <= w_paused_nx;
      r_pattern  <= w_pattern_nx;
      r_led      <= r_pattern & w_led_mask;
    end
  end

  assign led    = r_led;
  assign mode   = r_mode;
  assign paused = r_paused;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: a behavioural model predicts every post-edge output.
module tb_led_pattern_engine;
  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_status;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;

  led_pattern_engine #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .key_status(key_status),
    .led(led), .mode(mode), .paused(paused)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: pattern is a phase count k since the last reload; time is clocks since the last counter clear.
  int         m_mode, m_speed, m_k, m_elapsed, m_prev;
  bit         m_paused;
  logic [3:0] m_led;
  int         m_pwm, m_bright;

  function automatic logic [3:0] pattern_bits(input int md, input int k);
    case (md)
      1:       return 4'(1 << (k % 4));
      2:       return ((k % 2) == 0) ? 4'hF : 4'h0;
      3:       return 4'(k % 16);
      default: return 4'h0;
    endcase
  endfunction

  function automatic int period_clocks(input int spd);
    return TD * ((spd == 0) ? 4 : ((spd == 1) ? 2 : 1));
  endfunction

  task automatic model_edge(input logic rst, input logic [2:0] key);
    bit accept;
    if (rst) begin
      m_mode = 0; m_speed = 0; m_k = 0; m_elapsed = 0; m_prev = 0;
      m_paused = 1'b0; m_led = 4'h0; m_pwm = 0; m_bright = 3;
    end else begin
      m_led = pattern_bits(m_mode, m_k);
`ifdef LED_PWM_EN
      if (m_pwm >= 4 * (m_bright + 1)) m_led = 4'h0;
      m_pwm = (m_pwm + 1) % 16;
`endif
      accept = (key != 3'd0) && (m_prev == 0);
      m_prev = int'(key);
      if (!m_paused) begin
        m_elapsed++;
        if (m_elapsed == period_clocks(m_speed)) begin
          m_elapsed = 0;
          m_k++;
        end
      end
      if (accept) begin
        case (key)
          3'd1: begin m_mode = (m_mode + 1) % 4; m_k = 0; m_elapsed = 0; end
          3'd2: begin m_speed = (m_speed + 1) % 3; m_elapsed = 0; end
          3'd3: m_paused = !m_paused;
`ifdef LED_PWM_EN
          3'd4: m_bright = (m_bright + 3) % 4;
`endif
          default: ;
        endcase
      end
    end
  endtask

  task automatic drive_edge(input logic rst, input logic [2:0] key);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    key_status = key;
    model_edge(rst, key);
    e.led    = m_led;
    e.mode   = 2'(m_mode);
    e.paused = m_paused;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_edge(1'b0, 3'd0);
  endtask

  task automatic pulse(input logic [2:0] code);
    drive_edge(1'b0, code);
    drive_edge(1'b0, 3'd0);
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    for (int i = 0; i < n; i++) drive_edge(1'b0, code);
  endtask

  // Monitor: compare outputs just after each active edge against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led cycle %0d: got %b expected %b", cyc, led, e.led);
        end
        checks++;
        if (mode !== e.mode) begin
          errors++;
          $display("FAIL mode cycle %0d: got %0d expected %0d", cyc, mode, e.mode);
        end
        checks++;
        if (paused !== e.paused) begin
          errors++;
          $display("FAIL paused cycle %0d: got %0b expected %0b", cyc, paused, e.paused);
        end
      end
    end
  end

  initial begin
    int code, len, gap;
    reset      = 1'b1;
    key_status = 3'd0;
    drive_edge(1'b1, 3'd0);
    drive_edge(1'b1, 3'd0);
    // Basic step timing from mode 1.
    pulse(3'd1);
    idle(40);
    // Speed up twice, watch the running light wrap.
    pulse(3'd2);
    idle(2);
    pulse(3'd2);
    idle(40);
    // Counter mode through its wrap, then held and direct-changed codes.
    pulse(3'd1);
    pulse(3'd1);
    idle(80);
    hold(3'd1, 50);
    idle(2);
    drive_edge(1'b0, 3'd1);
    hold(3'd2, 5);
    idle(10);
    // Blink mode with a long pause and resume.
    pulse(3'd1);
    idle(10);
    pulse(3'd3);
    idle(100);
    pulse(3'd3);
    idle(20);
    // Back to slow speed, reset in the middle of a step period.
    pulse(3'd2);
    idle(11);
    drive_edge(1'b1, 3'd0);
    idle(40);
    // Brightness and reserved codes, including in paused blink.
    pulse(3'd1);
    pulse(3'd1);
    pulse(3'd3);
    pulse(3'd4);
    idle(20);
    pulse(3'd5);
    pulse(3'd6);
    pulse(3'd7);
    pulse(3'd3);
    idle(20);
    // Randomized key traffic with occasional resets.
    for (int n = 0; n < 250; n++) begin
      code = $urandom_range(7, 0);
      len  = $urandom_range(4, 1);
      gap  = $urandom_range(15, 0);
      if ($urandom_range(59, 0) == 0) drive_edge(1'b1, 3'd0);
      hold(3'(code), len);
      idle(gap);
    end
    idle(3);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
